alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath width; legal values 8, 16, 32, 64.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port InValid  input  1  operand/opcode presented.
REQ-005 Port InReady  output  1  block can accept; SHALL equal (state == IDLE).
REQ-006 Port SrcA  input  XLEN  first operand.
REQ-007 Port SrcB  input  XLEN  second operand / shift amount.
REQ-008 Port ALUControl  input  4  operation select, per REQ-012.
REQ-009 Port OutValid  output  1  result available.
REQ-010 Port OutReady  input  1  consumer accepts result.
REQ-011 Ports ALUResult  output  XLEN  registered result; Zero  output  1  registered (ALUResult == 0).

Function
REQ-012 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT signed, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU, 1010 MUL (low XLEN bits), 1011 MULHU (high XLEN bits, unsigned), 1100 DIVU, 1101 REMU; 1110/1111 SHALL yield result 0 as single-cycle ops.
REQ-013 Input transfer SHALL occur on a clk edge where InValid && InReady; SrcA, SrcB, ALUControl SHALL be captured then and ignored afterwards.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE + transfer of opcode 0000-1001 or 1110-1111 -> DONE; result computed and registered on the transfer edge (OutValid high 1 cycle after transfer).
REQ-016 IDLE + transfer of opcode 1010-1101 -> BUSY; iteration counter loaded with XLEN.
REQ-017 BUSY SHALL perform one shift-add (MUL/MULHU) or one restoring-division step (DIVU/REMU) per cycle; after XLEN steps -> DONE (OutValid high XLEN+1 cycles after transfer).
REQ-018 DONE: OutValid = 1; ALUResult and Zero SHALL stay stable while OutReady = 0; DONE && OutReady -> IDLE on that edge.
REQ-019 InValid while not IDLE SHALL be ignored (InReady = 0); no operand is queued.
REQ-020 Add/sub SHALL wrap modulo 2^XLEN; no carry/overflow outputs.
REQ-021 Shifts SHALL use only SrcB[log2(XLEN)-1:0]; SRA replicates SrcA[XLEN-1].
REQ-022 SLT/SLTU SHALL produce 1 or 0 zero-extended to XLEN.
REQ-023 DIVU by zero SHALL return all ones; REMU by zero SHALL return SrcA; both still take XLEN+1 cycles.
REQ-024 MUL/MULHU SHALL use the full 2*XLEN-bit unsigned product internally.
REQ-025 OutValid SHALL never be high in IDLE or BUSY.

Reset
REQ-026 reset asserted SHALL immediately force state IDLE, OutValid 0, ALUResult 0, Zero 0, counter 0, iterative datapath registers 0.
REQ-027 reset asserted during BUSY or DONE SHALL abort the operation; no result is ever presented for it.
REQ-028 InReady SHALL be 1 from the first cycle after reset deassertion.

Structure
REQ-029 Package alu_pkg SHALL hold the 4-bit opcode enumeration (REQ-012), FSM state typedef and default XLEN constant.
REQ-030 Iterative multiply/divide datapath (partial product/remainder, quotient, counter) SHALL be sub-module mdu_iter with start/done handshake; alu_iter holds FSM, single-cycle ops and output registers.

Verification
REQ-031 XLEN=32: ADD SrcA=0xFFFFFFFF, SrcB=1 -> OutValid 1 cycle after transfer, ALUResult 0, Zero 1.
REQ-032 SRA SrcA=0x80000000, SrcB=0x00000024 (shift 4) -> 0xF8000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE exactly 33 cycles after transfer; MUL same operands -> 0x00000001.
REQ-034 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 OutReady held 0 for 5 cycles in DONE -> ALUResult/Zero unchanged, InReady 0, InValid pulses ignored; OutReady 1 -> IDLE next edge, InReady 1.
REQ-036 reset pulsed mid-BUSY of DIVU -> OutValid 0, ALUResult 0 immediately; next ADD 2+3 -> 5 with normal 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and width definitions for the iterative ALU.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_SRL   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101,
    OP_RSV0  = 4'b1110,
    OP_RSV1  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } alu_state_e;

  function automatic logic is_iterative(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per cycle.
// done is asserted during the final step; result is the value that step produces.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  alu_op_e         op_q, op_d;
  logic            is_mul;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // hi holds the upper product / running remainder; lo holds multiplier bits / quotient.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    is_mul  = (op_q == OP_MUL) || (op_q == OP_MULHU);
    if (start) begin
      hi_d  = '0;
      lo_d  = a;
      b_d   = b;
      op_d  = op;
      cnt_d = CW'(XLEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (is_mul) begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end else begin
        // A zero divisor never borrows, giving all-ones quotient and remainder = dividend.
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        if (!diff[XLEN]) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end
    end
    done   = (cnt_q == CW'(1)) && !start;
    result = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? lo_d : hi_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      op_q  <= OP_MUL;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// ALU with valid/ready handshake: single-cycle ops finish on the transfer edge,
// multiply/divide run XLEN steps in mdu_iter; result is held until accepted.
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [3:0]      ALUControl,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  alu_op_e         op_in;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] comb_result;
  logic            mdu_start;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_result;

  assign op_in = alu_op_e'(ALUControl);
  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    comb_result = '0;
    case (op_in)
      OP_ADD:  comb_result = SrcA + SrcB;
      OP_SUB:  comb_result = SrcA - SrcB;
      OP_AND:  comb_result = SrcA & SrcB;
      OP_OR:   comb_result = SrcA | SrcB;
      OP_XOR:  comb_result = SrcA ^ SrcB;
      OP_SLT:  comb_result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLL:  comb_result = SrcA << shamt;
      OP_SRL:  comb_result = SrcA >> shamt;
      OP_SRA:  comb_result = $signed(SrcA) >>> shamt;
      OP_SLTU: comb_result = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      default: comb_result = '0;
    endcase
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (mdu_start),
    .op     (op_in),
    .a      (SrcA),
    .b      (SrcB),
    .done   (mdu_done),
    .result (mdu_result)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    mdu_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (InValid) begin
          if (is_iterative(op_in)) begin
            mdu_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            result_d = comb_result;
            zero_d   = (comb_result == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (mdu_done) begin
          result_d = mdu_result;
          zero_d   = (mdu_result == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (OutReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign InReady   = (state_q == ST_IDLE);
  assign OutValid  = (state_q == ST_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at XLEN=32 with hand-computed expectations.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  ALUControl;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] ALUResult;
  logic        Zero;

  int errors = 0;
  int checks = 0;
  int lat;
  int seen;

  alu_iter #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operation, scramble inputs after the transfer edge, then count
  // cycles (sampled on falling edges) until OutValid, bounded at 100.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int latency);
    @(negedge clk);
    InValid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    checkOutput("in_ready_before_transfer", {63'd0, InReady}, 64'd1);
    @(posedge clk);
    #1;
    InValid = 1'b0; ALUControl = 4'b0000; SrcA = 32'hDEADBEEF; SrcB = 32'h00000005;
    latency = 1;
    @(negedge clk);
    while (!OutValid && latency < 100) begin
      @(negedge clk);
      latency++;
    end
  endtask

  task automatic acceptResult();
    OutReady = 1'b1;
    @(posedge clk);
    #1;
    OutReady = 1'b0;
    checkOutput("in_ready_after_accept", {63'd0, InReady}, 64'd1);
    checkOutput("out_valid_after_accept", {63'd0, OutValid}, 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int l;
    applyStimulus(op, a, b, l);
    checkOutput({tag, "_latency"}, 64'(l), 64'(exp_lat));
    checkOutput({tag, "_result"}, {32'd0, ALUResult}, {32'd0, exp_res});
    checkOutput({tag, "_zero"}, {63'd0, Zero}, {63'd0, (exp_res == 32'd0)});
    acceptResult();
  endtask

  initial begin
    reset = 1'b1; InValid = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0; OutReady = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", {63'd0, OutValid}, 64'd0);
    checkOutput("reset_result", {32'd0, ALUResult}, 64'd0);
    checkOutput("reset_zero", {63'd0, Zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_reset", {63'd0, InReady}, 64'd1);

    runOp("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    runOp("sub",      4'b0001, 32'd5,        32'd7,        32'hFFFFFFFE, 1);
    runOp("and",      4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1);
    runOp("or",       4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1);
    runOp("xor",      4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1);
    runOp("sra",      4'b1000, 32'h80000000, 32'h00000024, 32'hF8000000, 1);
    runOp("sll",      4'b0110, 32'h00000001, 32'h00000021, 32'h00000002, 1);
    runOp("srl",      4'b0111, 32'h80000000, 32'h0000001F, 32'h00000001, 1);
    runOp("slt",      4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
    runOp("sltu",     4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    runOp("rsv_e",    4'b1110, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);
    runOp("rsv_f",    4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);
    runOp("mulhu",    4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    runOp("mul",      4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    runOp("mul_dec",  4'b1010, 32'd12345,    32'd1000,     32'd12345000, 33);
    runOp("divu_z",   4'b1100, 32'd100,      32'd0,        32'hFFFFFFFF, 33);
    runOp("remu_z",   4'b1101, 32'd100,      32'd0,        32'd100,      33);
    runOp("divu",     4'b1100, 32'd100,      32'd7,        32'd14,       33);
    runOp("remu",     4'b1101, 32'd100,      32'd7,        32'd2,        33);

    // Result held while OutReady is low; InValid pulses must be ignored.
    applyStimulus(4'b1100, 32'd100, 32'd7, lat);
    checkOutput("hold_latency", 64'(lat), 64'd33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      InValid = 1'b1; ALUControl = 4'b0000; SrcA = 32'd1; SrcB = 32'd1;
      checkOutput("hold_result", {32'd0, ALUResult}, 64'd14);
      checkOutput("hold_zero", {63'd0, Zero}, 64'd0);
      checkOutput("hold_in_ready", {63'd0, InReady}, 64'd0);
      checkOutput("hold_out_valid", {63'd0, OutValid}, 64'd1);
    end
    @(negedge clk);
    InValid = 1'b0;
    acceptResult();
    @(negedge clk);
    checkOutput("no_queued_op", {63'd0, OutValid}, 64'd0);

    // Abort a divide mid-flight with reset.
    @(negedge clk);
    InValid = 1'b1; ALUControl = 4'b1100; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_out_valid", {63'd0, OutValid}, 64'd0);
    checkOutput("abort_result", {32'd0, ALUResult}, 64'd0);
    checkOutput("abort_in_ready", {63'd0, InReady}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (OutValid) seen++;
    end
    checkOutput("abort_no_result", 64'(seen), 64'd0);
    runOp("add_after_abort", 4'b0000, 32'd2, 32'd3, 32'd5, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
